// File: rtl/rv32i_defs.sv
// rv32i_defs: constants shared by the RV32I pipeline stages.
package rv32i_defs;
    localparam int XLEN = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {pc,instr} slot that catches a fetch response
// arriving while the pipeline is stalled.
module fetch_skid_buf import rv32i_defs::*; #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] pc_in,
    input  logic [W-1:0] instr_in,
    output logic         valid,
    output logic [W-1:0] pc,
    output logic [W-1:0] instr
);
    logic         valid_q, valid_d;
    logic [W-1:0] pc_q, pc_d, instr_q, instr_d;

    always_comb begin
        valid_d = clear ? 1'b0 : load ? 1'b1 : valid_q;
        pc_d    = load ? pc_in : pc_q;
        instr_d = load ? instr_in : instr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= W'(RV_NOP);
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;
endmodule

// File: rtl/if_stage.sv
// if_stage: RV32I fetch stage - PC, single-outstanding imem handshake, IF/ID register
// obeying stall_n/flush from the hazard unit.
module if_stage import rv32i_defs::*; #(
    parameter int              XLEN     = rv32i_defs::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_n,
    input  logic                     flush,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [XLEN-1:0]          imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [XLEN-1:0]          imem_rsp_data,
    output logic                     ifid_valid,
    output logic [XLEN-1:0]          ifid_pc,
    output logic [XLEN-1:0]          ifid_instr,
    output logic [RF_ADDR_WIDTH-1:0] ifid_rs1,
    output logic [RF_ADDR_WIDTH-1:0] ifid_rs2,
    output logic                     ifid_mem_write
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_KILL} fetch_state_e;

    fetch_state_e    st_q, st_d;
    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d;
    logic            buf_valid, buf_load, buf_clear, rsp_keep, fire;
    logic [XLEN-1:0] buf_pc, buf_instr;

    fetch_skid_buf #(.W(XLEN)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (buf_load),
        .clear    (buf_clear),
        .pc_in    (req_pc_q),
        .instr_in (imem_rsp_data),
        .valid    (buf_valid),
        .pc       (buf_pc),
        .instr    (buf_instr)
    );

    always_comb begin
        rsp_keep       = st_q == S_WAIT && imem_rsp_valid;
        imem_req_valid = rst_n && !flush && !buf_valid && (st_q == S_IDLE || (rsp_keep && stall_n));
        imem_req_addr  = pc_q;
        fire           = imem_req_valid && imem_req_ready;
        buf_load       = rsp_keep && !stall_n && !flush;
        buf_clear      = flush || (stall_n && buf_valid);
        pc_d           = flush ? (redirect_pc & ~XLEN'(3)) : fire ? pc_q + XLEN'(4) : pc_q;
        req_pc_d       = fire ? pc_q : req_pc_q;
        // an outstanding request that survives a flush must be swallowed when it lands
        st_d = flush ? ((st_q != S_IDLE && !imem_rsp_valid) ? S_KILL : S_IDLE)
             : fire ? S_WAIT : imem_rsp_valid ? S_IDLE : st_q;
        ifid_valid_d = flush ? 1'b0 : stall_n ? (buf_valid || rsp_keep) : ifid_valid_q;
        ifid_pc_d    = (flush || !stall_n) ? ifid_pc_q
                     : buf_valid ? buf_pc : rsp_keep ? req_pc_q : ifid_pc_q;
        ifid_instr_d = flush ? XLEN'(RV_NOP) : !stall_n ? ifid_instr_q
                     : buf_valid ? buf_instr : rsp_keep ? imem_rsp_data : XLEN'(RV_NOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= S_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= XLEN'(RV_NOP);
        end else begin
            st_q         <= st_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    assign ifid_valid     = ifid_valid_q;
    assign ifid_pc        = ifid_pc_q;
    assign ifid_instr     = ifid_instr_q;
    assign ifid_rs1       = ifid_instr_q[19:15];
    assign ifid_rs2       = ifid_instr_q[24:20];
    assign ifid_mem_write = ifid_valid_q && ifid_instr_q[6:0] == OPC_STORE;

    a_no_rsp_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && st_q == S_IDLE));
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenarios plus randomized traffic against a queue-based
// model of the fetch stage and a latency-configurable instruction memory.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n, stall_n, flush, imem_req_ready, imem_rsp_valid;
    logic [31:0] redirect_pc, imem_rsp_data;
    logic        imem_req_valid, ifid_valid, ifid_mem_write;
    logic [31:0] imem_req_addr, ifid_pc, ifid_instr;
    logic [4:0]  ifid_rs1, ifid_rs2;

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_n(stall_n), .flush(flush), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_mem_write(ifid_mem_write)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;

    int          checks = 0, errors = 0;
    int          mem_lat, pend_cnt;
    bit          pend, pend_kill, prev_hold, seen_req;
    logic [31:0] pend_addr, exp_pc, prev_addr, seen_addr;
    ent_t        q[$];
    logic        exp_valid;
    logic [31:0] exp_ifid_pc, exp_ifid_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a == 32'h40 ? 32'h00A12023 : (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // one clock: memory drives its response, request side is checked, then IF/ID after the edge
    task automatic tick();
        logic rv, fire, exp_rv;
        ent_t e;
        imem_rsp_valid = pend && pend_cnt == 1;
        imem_rsp_data  = imem_rsp_valid ? instr_of(pend_addr) : $urandom;
        #1;
        rv = imem_req_valid;
        seen_req = rv;
        seen_addr = imem_req_addr;
        fire = rv && imem_req_ready;
        exp_rv = !flush && q.size() == 0 && (!pend || (imem_rsp_valid && !pend_kill && stall_n));
        checks++;
        if (rv !== exp_rv) begin
            errors++;
            $display("FAIL req_valid t=%0t got %0b exp %0b", $time, rv, exp_rv);
        end
        checks++;
        if (rv && imem_req_addr !== exp_pc) begin
            errors++;
            $display("FAIL req_addr t=%0t got %h exp %h", $time, imem_req_addr, exp_pc);
        end
        checks++;
        if (prev_hold && !flush && (!rv || imem_req_addr !== prev_addr)) begin
            errors++;
            $display("FAIL req_hold t=%0t got v=%0b a=%h exp v=1 a=%h", $time, rv, imem_req_addr, prev_addr);
        end
        @(posedge clk);
        prev_hold = rv && !imem_req_ready;
        prev_addr = seen_addr;
        if (imem_rsp_valid) begin
            if (!pend_kill && !flush) q.push_back('{pend_addr, instr_of(pend_addr)});
            pend = 0;
        end else if (pend) begin
            pend_cnt--;
            if (flush) pend_kill = 1;
        end
        if (fire) begin
            pend = 1; pend_kill = 0; pend_cnt = mem_lat; pend_addr = seen_addr;
            exp_pc = exp_pc + 32'd4;
        end
        if (flush) begin
            exp_pc = redirect_pc & ~32'h3;
            q.delete();
            exp_valid = 0;
            exp_ifid_instr = NOP;
        end else if (stall_n) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                exp_valid = 1; exp_ifid_pc = e.pc; exp_ifid_instr = e.instr;
            end else begin
                exp_valid = 0; exp_ifid_instr = NOP;
            end
        end
        @(negedge clk);
        checks++;
        if (ifid_valid !== exp_valid) begin
            errors++;
            $display("FAIL ifid_valid t=%0t got %0b exp %0b", $time, ifid_valid, exp_valid);
        end
        checks++;
        if (ifid_instr !== exp_ifid_instr || (exp_valid && ifid_pc !== exp_ifid_pc)) begin
            errors++;
            $display("FAIL ifid_data t=%0t got pc=%h i=%h exp pc=%h i=%h", $time, ifid_pc, ifid_instr, exp_ifid_pc, exp_ifid_instr);
        end
        checks++;
        if (ifid_rs1 !== exp_ifid_instr[19:15] || ifid_rs2 !== exp_ifid_instr[24:20] ||
            ifid_mem_write !== (exp_valid && exp_ifid_instr[6:0] == 7'b0100011)) begin
            errors++;
            $display("FAIL decode t=%0t got rs1=%0d rs2=%0d mw=%0b", $time, ifid_rs1, ifid_rs2, ifid_mem_write);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; stall_n = 1; flush = 0; redirect_pc = 0; imem_req_ready = 1;
        imem_rsp_valid = 0; imem_rsp_data = 0; mem_lat = 1;
        pend = 0; pend_kill = 0; pend_cnt = 0; prev_hold = 0; q.delete();
        exp_pc = RST_PC; exp_valid = 0; exp_ifid_pc = 0; exp_ifid_instr = NOP;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; stall_n = 1; flush = 0; redirect_pc = 0; imem_req_ready = 1;
        imem_rsp_valid = 0; imem_rsp_data = 0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== NOP) begin
            errors++;
            $display("FAIL reset_state got rv=%0b v=%0b pc=%h i=%h", imem_req_valid, ifid_valid, ifid_pc, ifid_instr);
        end
        checks++;
        if (ifid_rs1 !== 5'd0 || ifid_rs2 !== 5'd0 || ifid_mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_decode got rs1=%0d rs2=%0d mw=%0b", ifid_rs1, ifid_rs2, ifid_mem_write);
        end
        do_reset();
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (!seen_req || seen_addr !== 32'(4 * k)) begin
                errors++;
                $display("FAIL stream_addr k=%0d got v=%0b a=%h exp a=%h", k, seen_req, seen_addr, 32'(4 * k));
            end
            checks++;
            if (k == 0 ? ifid_valid !== 1'b0 : (ifid_valid !== 1'b1 || ifid_pc !== 32'(4 * (k - 1)))) begin
                errors++;
                $display("FAIL stream_ifid k=%0d got v=%0b pc=%h", k, ifid_valid, ifid_pc);
            end
        end
    endtask

    task automatic test_stall();
        bit found = 0;
        do_reset();
        repeat (3) tick();
        stall_n = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (seen_req !== 1'b0 || ifid_valid !== 1'b1 || ifid_pc !== 32'h4) begin
                errors++;
                $display("FAIL stall_hold k=%0d got rv=%0b v=%0b pc=%h exp rv=0 v=1 pc=4", k, seen_req, ifid_valid, ifid_pc);
            end
        end
        stall_n = 1;
        tick();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8) begin
            errors++;
            $display("FAIL stall_release got v=%0b pc=%h exp v=1 pc=8", ifid_valid, ifid_pc);
        end
        for (int k = 0; k < 4 && !found; k++) begin
            tick();
            found = ifid_valid;
        end
        checks++;
        if (!found || ifid_pc !== 32'hC) begin
            errors++;
            $display("FAIL stall_next got found=%0b pc=%h exp pc=c", found, ifid_pc);
        end
    endtask

    task automatic test_flush();
        bit got_req = 0, found = 0;
        logic [31:0] first_addr = 0;
        do_reset();
        repeat (4) tick();
        mem_lat = 2;
        tick();
        mem_lat = 1;
        checks++;
        if (!seen_req || seen_addr !== 32'h10) begin
            errors++;
            $display("FAIL flush_setup got v=%0b a=%h exp a=10", seen_req, seen_addr);
        end
        flush = 1; redirect_pc = 32'h100;
        tick();
        flush = 0;
        checks++;
        if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin
            errors++;
            $display("FAIL flush_bubble got v=%0b i=%h exp v=0 i=%h", ifid_valid, ifid_instr, NOP);
        end
        for (int k = 0; k < 8 && !found; k++) begin
            tick();
            if (seen_req && !got_req) begin
                got_req = 1;
                first_addr = seen_addr;
            end
            found = ifid_valid;
        end
        checks++;
        if (!got_req || first_addr !== 32'h100) begin
            errors++;
            $display("FAIL flush_target_req got v=%0b a=%h exp a=100", got_req, first_addr);
        end
        checks++;
        if (!found || ifid_pc !== 32'h100) begin
            errors++;
            $display("FAIL flush_target_ifid got v=%0b pc=%h exp pc=100", found, ifid_pc);
        end
    endtask

    task automatic test_flush_rsp();
        do_reset();
        repeat (3) tick();
        flush = 1; redirect_pc = 32'h203;
        tick();
        flush = 0;
        tick();
        checks++;
        if (!seen_req || seen_addr !== 32'h200 || ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_rsp_req got rv=%0b a=%h v=%0b exp rv=1 a=200 v=0", seen_req, seen_addr, ifid_valid);
        end
        tick();
        checks++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h200 || ifid_instr !== instr_of(32'h200)) begin
            errors++;
            $display("FAIL flush_rsp_ifid got v=%0b pc=%h i=%h exp pc=200", ifid_valid, ifid_pc, ifid_instr);
        end
    endtask

    task automatic test_store();
        bit found = 0;
        do_reset();
        for (int k = 0; k < 24 && !found; k++) begin
            tick();
            found = ifid_valid && ifid_pc == 32'h40;
        end
        checks++;
        if (!found || ifid_mem_write !== 1'b1 || ifid_rs1 !== 5'd2 || ifid_rs2 !== 5'd10) begin
            errors++;
            $display("FAIL store_decode got found=%0b mw=%0b rs1=%0d rs2=%0d exp mw=1 rs1=2 rs2=10", found, ifid_mem_write, ifid_rs1, ifid_rs2);
        end
        flush = 1; redirect_pc = 32'h0;
        tick();
        flush = 0;
        checks++;
        if (ifid_mem_write !== 1'b0 || ifid_rs1 !== 5'd0 || ifid_rs2 !== 5'd0) begin
            errors++;
            $display("FAIL bubble_decode got mw=%0b rs1=%0d rs2=%0d exp 0", ifid_mem_write, ifid_rs1, ifid_rs2);
        end
    endtask

    task automatic test_ready_low();
        do_reset();
        imem_req_ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (!seen_req || seen_addr !== 32'h0 || ifid_valid !== 1'b0) begin
                errors++;
                $display("FAIL ready_low k=%0d got v=%0b a=%h iv=%0b exp v=1 a=0", k, seen_req, seen_addr, ifid_valid);
            end
        end
        imem_req_ready = 1;
        tick();
        tick();
        checks++;
        if (!seen_req || seen_addr !== 32'h4) begin
            errors++;
            $display("FAIL ready_resume got v=%0b a=%h exp a=4", seen_req, seen_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (3) tick();
        mem_lat = 3;
        tick();
        rst_n = 0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== NOP || ifid_mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got rv=%0b v=%0b pc=%h i=%h", imem_req_valid, ifid_valid, ifid_pc, ifid_instr);
        end
        do_reset();
        tick();
        checks++;
        if (!seen_req || seen_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_restart got v=%0b a=%h exp a=%h", seen_req, seen_addr, RST_PC);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            stall_n = ($urandom % 5) != 0;
            flush = ($urandom % 14) == 0;
            redirect_pc = $urandom & 32'h0000_0fff;
            imem_req_ready = ($urandom % 4) != 0;
            mem_lat = 1 + $urandom % 3;
            tick();
        end
        stall_n = 1; flush = 0; imem_req_ready = 1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_flush_rsp();
        test_store();
        test_ready_low();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
